mem_responder_4b: RTL
=====================

MEM_RESPONDER_4B -- requirements
Module: mem_responder_4b

Interface
REQ-001 SHALL have parameter p_num_words, default 256, number of 32-bit words stored; power of two, 16..4096.
REQ-002 SHALL have parameter p_latency, default 0, extra cycles between request acceptance and response valid; range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port reqstream_val  input  1  request valid.
REQ-006 SHALL have port reqstream_rdy  output  1  request ready.
REQ-007 SHALL have port reqstream_msg  input  77  mem_req_4B_t with fields type[3], opaque[8], addr[32], len[2], data[32].
REQ-008 SHALL have port respstream_val  output  1  response valid.
REQ-009 SHALL have port respstream_rdy  input  1  response ready.
REQ-010 SHALL have port respstream_msg  output  47  mem_resp_4B_t with fields type[3], opaque[8], test[2], len[2], data[32].

Function
REQ-011 SHALL accept a request only on a cycle with reqstream_val && reqstream_rdy, and emit a response only on a cycle with respstream_val && respstream_rdy.
REQ-012 SHALL use an FSM with states IDLE, WAIT and RESP.
- IDLE: reqstream_rdy=1; on accept, go to WAIT if p_latency>0, else RESP.
- WAIT: count down p_latency cycles, then go to RESP.
- RESP: respstream_val=1.
REQ-013 SHALL, in RESP, assert reqstream_rdy = respstream_rdy, so that a response handoff and a new acceptance occur in the same cycle; with p_latency=0 this sustains one transaction per cycle.
REQ-014 SHALL, in RESP, go to IDLE when the response fires and no request is accepted that cycle.
REQ-015 SHALL hold respstream_msg stable while respstream_val=1 and respstream_rdy=0.
REQ-016 SHALL derive the word index as addr[$clog2(p_num_words)+1:2] and ignore higher address bits, so addresses wrap modulo 4*p_num_words.
REQ-017 SHALL treat len=0 as 4 bytes and len=1..3 as that many bytes, starting at byte offset addr[1:0].
REQ-018 SHALL define a request as crossing the word boundary when addr[1:0] + bytes > 4.
REQ-019 SHALL, for read (type 0), capture data at acceptance, zero-extended, with the selected bytes right-aligned.
REQ-020 SHALL, for write (type 1), update only the selected bytes at the acceptance edge; response data=0.
REQ-021 SHALL make a write accepted in cycle N visible to a read accepted in cycle N+1.
REQ-022 SHALL echo type, opaque and len from the request into the response.
REQ-023 SHALL set test=2'b00 on success and test=2'b01 for a boundary-crossing request, which has no memory effect and returns data=0.
REQ-024 SHALL treat any other type as a no-op and respond with test=2'b10 and data=0.

Reset
REQ-025 SHALL, while reset=0, force the FSM to IDLE, the latency counter to 0 and respstream_val=0, and SHALL drive respstream_msg=0.
REQ-026 SHALL, while reset=0, hold reqstream_rdy=0; reqstream_rdy SHALL rise in the first cycle after deassertion.
REQ-027 SHALL not reset storage contents.
REQ-028 SHALL, on reset mid-transaction, silently drop the pending response while writes already committed persist.

Structure
REQ-029 SHALL place the FSM state enum, the test codes (OK, MISALIGN, BADTYPE) and the request-type constants in shared package mem_responder_pkg.
REQ-030 SHALL instantiate one sub-module, mem_responder_4b_array: a p_num_words x 32 array with 4-bit byte enables, a combinational read port and a synchronous write port.

Verification
REQ-031 SHALL cover this scenario with p_latency=0, respstream_rdy=1: write 0xDEADBEEF @0x1000 (len 0), then read @0x1000 -> read response data=0xDEADBEEF and test=0, one response per cycle.
REQ-032 SHALL cover this scenario: byte write 0xAB @0x1002 (len 1), then word read @0x1000 -> data=0xDEABBEEF.
REQ-033 SHALL cover this scenario with p_latency=3: read accepted in cycle N -> respstream_val rises in cycle N+4, and reqstream_rdy=0 during cycles N+1..N+3.
REQ-034 SHALL cover this scenario: respstream_rdy held 0 for 5 cycles in RESP -> message stable, no new request accepted, response fires on the first ready cycle.
REQ-035 SHALL cover these error scenarios.
- Halfword write @0x3 -> test=2'b01, and a following read shows memory unchanged.
- type=2 -> test=2'b10.
- With p_num_words=256, read @0x400 -> returns the word @0x000.
REQ-036 SHALL cover this scenario: reset=0 asserted in WAIT -> respstream_val=0 immediately, no response after release, and earlier writes still readable.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_responder_pkg                                      |
// | Description : Shared types, constants and helpers for the 4-byte     |
// |               memory responder (FSM states, test codes, msg formats) |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_responder_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Response status codes
    localparam logic [1:0] c_TEST_OK       = 2'b00;
    localparam logic [1:0] c_TEST_MISALIGN = 2'b01;
    localparam logic [1:0] c_TEST_BADTYPE  = 2'b10;

    // Request type codes
    localparam logic [2:0] c_TYPE_READ  = 3'd0;
    localparam logic [2:0] c_TYPE_WRITE = 3'd1;

    // Request message, 77 bits, type in the MSBs
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    // Response message, 47 bits, type in the MSBs
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // len encodes 1..3 bytes directly; 0 means a full 4-byte word
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

    // Byte-lane mask for an access of nbytes starting at lane 0
    function automatic logic [3:0] bytes_to_be(input logic [2:0] nbytes);
        logic [3:0] be;
        case (nbytes)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Expand a byte-lane mask into a 32-bit bit mask
    function automatic logic [31:0] be_to_mask32(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_4b_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_responder_4b_array                                 |
// | Description : NUM_WORDS x 32 storage, byte-enabled synchronous write,|
// |               combinational read; contents are never reset           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_responder_4b_array #(
    parameter int NUM_WORDS = 256
) (
    input  logic                         clk,
    input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
    output logic [31:0]                  rdata_o,
    input  logic                         we_i,
    input  logic [3:0]                   wbe_i,
    input  logic [31:0]                  wdata_i
);

    // One independent 8-bit lane per byte so each byte enable owns its storage
    for (genvar b = 0; b < 4; b++) begin : g_byte
        logic [7:0] r_lane_q [NUM_WORDS];

        // Commit the enabled byte on the clock edge
        always_ff @(posedge clk) begin
            if (we_i && wbe_i[b]) begin
                r_lane_q[addr_i] <= wdata_i[8*b +: 8];
            end
        end

        assign rdata_o[8*b +: 8] = r_lane_q[addr_i];
    end

endmodule : mem_responder_4b_array
`default_nettype wire

// File: rtl/mem_responder_4b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_responder_4b                                       |
// | Description : Single-ported 4-byte memory responder with val/rdy     |
// |               request and response streams and optional latency      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_responder_4b
    import mem_responder_pkg::*;
#(
    parameter int p_num_words = 256,
    parameter int p_latency   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqstream_val,
    output logic         reqstream_rdy,
    input  mem_req_4B_t  reqstream_msg,
    output logic         respstream_val,
    input  logic         respstream_rdy,
    output mem_resp_4B_t respstream_msg
);

    localparam int         c_AW          = $clog2(p_num_words);
    localparam logic [3:0] c_LAT_LOAD    = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;
    localparam state_e     c_POST_ACCEPT = (p_latency > 0) ? ST_WAIT : ST_RESP;

    state_e       r_state_q, w_state_d;
    logic [3:0]   r_cnt_q, w_cnt_d;
    mem_resp_4B_t r_resp_q, w_resp_d;

    logic             w_accept;
    logic [c_AW-1:0]  w_idx;
    logic [1:0]       w_off;
    logic [2:0]       w_nbytes;
    logic             w_cross;
    logic             w_is_read;
    logic             w_is_write;
    logic             w_we;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic [31:0]      w_rd_aligned;
    logic             w_unused_addr;

    // Address decode: high address bits above the array simply wrap
    assign w_idx         = reqstream_msg.addr[c_AW+1:2];
    assign w_off         = reqstream_msg.addr[1:0];
    assign w_unused_addr = ^reqstream_msg.addr[31:c_AW+2];
    assign w_nbytes      = len_to_bytes(reqstream_msg.len);
    assign w_cross       = ({1'b0, w_off} + w_nbytes) > 3'd4;
    assign w_is_read     = (reqstream_msg.msg_type == c_TYPE_READ);
    assign w_is_write    = (reqstream_msg.msg_type == c_TYPE_WRITE);

    // Write lanes are shifted up to the byte offset; read data shifted down
    assign w_be          = bytes_to_be(w_nbytes) << w_off;
    assign w_wdata       = reqstream_msg.data << {w_off, 3'b000};
    assign w_rd_aligned  = (w_rdata >> {w_off, 3'b000})
                         & be_to_mask32(bytes_to_be(w_nbytes));
    assign w_we          = w_accept && w_is_write && !w_cross;

    mem_responder_4b_array #(
        .NUM_WORDS (p_num_words)
    ) u_array (
        .clk     (clk),
        .addr_i  (w_idx),
        .rdata_o (w_rdata),
        .we_i    (w_we),
        .wbe_i   (w_be),
        .wdata_i (w_wdata)
    );

    // FSM next state, handshake outputs and acceptance decision
    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        reqstream_rdy  = 1'b0;
        respstream_val = 1'b0;
        w_accept       = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                // Gated by reset so ready stays low while reset is held
                reqstream_rdy = reset;
                w_accept      = reqstream_val && reset;
                if (w_accept) begin
                    w_state_d = c_POST_ACCEPT;
                    w_cnt_d   = c_LAT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // A new request is taken only in the cycle the response leaves
                respstream_val = 1'b1;
                reqstream_rdy  = respstream_rdy;
                w_accept       = reqstream_val && respstream_rdy;
                if (w_accept) begin
                    w_state_d = c_POST_ACCEPT;
                    w_cnt_d   = c_LAT_LOAD;
                end else if (respstream_rdy) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Build the response message at acceptance, otherwise hold it
    always_comb begin
        w_resp_d = r_resp_q;
        if (w_accept) begin
            w_resp_d.msg_type = reqstream_msg.msg_type;
            w_resp_d.opaque   = reqstream_msg.opaque;
            w_resp_d.len      = reqstream_msg.len;
            w_resp_d.test     = c_TEST_OK;
            w_resp_d.data     = 32'd0;
            if (!w_is_read && !w_is_write) begin
                w_resp_d.test = c_TEST_BADTYPE;
            end else if (w_cross) begin
                w_resp_d.test = c_TEST_MISALIGN;
            end else if (w_is_read) begin
                w_resp_d.data = w_rd_aligned;
            end
        end
    end

    // State, latency counter and response register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 4'd0;
            r_resp_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_resp_q  <= w_resp_d;
        end
    end

    assign respstream_msg = r_resp_q;

endmodule : mem_responder_4b
`default_nettype wire
